// File: rtl/decode_imm_stage.sv
// -----------------------------------------------------------------------------
// decode_imm_stage
// IF/ID pipeline stage of the pipelined OTTER core.
// - Accepts fetched {instr, pc} beats on a valid/ready handshake.
// - Holds up to two beats: a main register that drives out_* and a skid buffer.
// - Pre-decodes the opcode into the immediate extender's 3-bit format select.
// - Slices the raw 25-bit immediate field.
// - A flush empties the stage and drops any same-cycle input beat.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   flush        synchronous squash of held entries and same-cycle input
//   in_valid     fetch presents a beat
//   in_ready     stage can accept a beat (state-derived, gated by reset)
//   in_instr     fetched instruction word
//   in_pc        PC of in_instr
//   out_valid    out_* holds a live instruction
//   out_ready    downstream consumes the beat
//   out_instr    held instruction
//   out_pc       held PC
//   out_imm      out_instr[31:7], raw immediate field
//   out_imm_src  immediate format: 0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J
//   out_illegal  opcode not recognised, or instr[1:0] != 2'b11
// -----------------------------------------------------------------------------
module decode_imm_stage #(
    parameter int          PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [24:0]     out_imm,
    output logic [2:0]      out_imm_src,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [24:0]     imm;
        logic [2:0]      imm_src;
        logic            illegal;
    } entry_t;

    // Returns {illegal, imm_src} for an instruction word.
    function automatic logic [3:0] decode_fmt(input logic [31:0] instr);
        logic [3:0] r;
        case (instr[6:0])
            7'b0010011, 7'b0000011,
            7'b1100111, 7'b1110011: r = {1'b0, 3'd1};
            7'b0100011:             r = {1'b0, 3'd2};
            7'b1100011:             r = {1'b0, 3'd3};
            7'b0110111, 7'b0010111: r = {1'b0, 3'd4};
            7'b1101111:             r = {1'b0, 3'd5};
            7'b0110011:             r = {1'b0, 3'd0};
            default:                r = {1'b1, 3'd0};
        endcase
        // Compressed / reserved encodings are never legal here.
        if (instr[1:0] != 2'b11) begin
            r[3] = 1'b1;
        end else begin
            r[3] = r[3];
        end
        return r;
    endfunction

    // Builds a fully decoded entry from a raw {instr, pc} beat.
    function automatic entry_t make_entry(input logic [31:0] instr,
                                          input logic [PC_W-1:0] pc);
        entry_t     e;
        logic [3:0] d;
        d         = decode_fmt(instr);
        e.instr   = instr;
        e.pc      = pc;
        e.imm     = instr[31:7];
        e.imm_src = d[2:0];
        e.illegal = d[3];
        return e;
    endfunction

    state_t state_r, state_nxt_s;
    entry_t main_r, main_nxt_s;
    entry_t skid_r, skid_nxt_s;
    entry_t nop_entry_s;
    entry_t in_entry_s;
    logic   accept_s;
    logic   consume_s;

    // Cleared payload: NOP at pc 0, always reported as legal.
    always_comb begin
        nop_entry_s         = make_entry(NOP_INSTR, {PC_W{1'b0}});
        nop_entry_s.illegal = 1'b0;
    end

    // Decode on the input side so each entry is stored pre-decoded.
    always_comb begin
        in_entry_s = make_entry(in_instr, in_pc);
    end

    // Handshake qualifiers; in_ready never depends on out_ready.
    always_comb begin
        in_ready  = (state_r != ST_TWO) & ~reset;
        out_valid = (state_r != ST_EMPTY);
        accept_s  = in_valid & in_ready;
        consume_s = out_valid & out_ready;
    end

    // Next-state and next-payload selection; flush wins over any handshake.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
            main_nxt_s  = nop_entry_s;
            skid_nxt_s  = nop_entry_s;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ST_ONE;
                        main_nxt_s  = in_entry_s;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && consume_s) begin
                        main_nxt_s = in_entry_s;
                    end else if (accept_s) begin
                        // Main is stalled; park the new beat in the skid.
                        state_nxt_s = ST_TWO;
                        skid_nxt_s  = in_entry_s;
                    end else if (consume_s) begin
                        // Draining to empty leaves the cleared NOP visible.
                        state_nxt_s = ST_EMPTY;
                        main_nxt_s  = nop_entry_s;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (consume_s) begin
                        state_nxt_s = ST_ONE;
                        main_nxt_s  = skid_r;
                        skid_nxt_s  = nop_entry_s;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    main_nxt_s  = nop_entry_s;
                    skid_nxt_s  = nop_entry_s;
                end
            endcase
        end
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
            main_r  <= nop_entry_s;
            skid_r  <= nop_entry_s;
        end else begin
            state_r <= state_nxt_s;
            main_r  <= main_nxt_s;
            skid_r  <= skid_nxt_s;
        end
    end

    // Outputs come straight from the main register.
    always_comb begin
        out_instr   = main_r.instr;
        out_pc      = main_r.pc;
        out_imm     = main_r.imm;
        out_imm_src = main_r.imm_src;
        out_illegal = main_r.illegal;
    end

endmodule
